// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
// Bundles the functional-unit / load result handshake and the common data bus
// broadcast that cdb_arbiter terminates and drives.
//
// Signals:
//   valid_out_bus[3:0]  FU i holds a result on out_i
//   out_0..out_3        FU result packets, held stable until yumi
//   load_valid          ROB has a completed load on out_load
//   out_load            load result packet
//   yumi_bus[3:0]       FU i result consumed this cycle
//   load_yumi           load result consumed this cycle
//   CDB                 registered broadcast packet
//   cdb_valid           CDB carries a valid broadcast this cycle
//   cdb_src             broadcast source: 0-3 = FU index, 4 = load
//
// Modports:
//   master  producer/consumer side (drives valids and packets, sees yumi and CDB)
//   slave   the arbiter
interface cdb_arbiter_if;

  typedef struct packed {
    logic [4:0]  rob_entry;
    logic [31:0] value;
  } CDB_packet_t;

  logic [3:0]  valid_out_bus;
  CDB_packet_t out_0;
  CDB_packet_t out_1;
  CDB_packet_t out_2;
  CDB_packet_t out_3;
  logic        load_valid;
  CDB_packet_t out_load;

  logic [3:0]  yumi_bus;
  logic        load_yumi;
  CDB_packet_t CDB;
  logic        cdb_valid;
  logic [2:0]  cdb_src;

  modport master (
    output valid_out_bus, out_0, out_1, out_2, out_3, load_valid, out_load,
    input  yumi_bus, load_yumi, CDB, cdb_valid, cdb_src
  );

  modport slave (
    input  valid_out_bus, out_0, out_1, out_2, out_3, load_valid, out_load,
    output yumi_bus, load_yumi, CDB, cdb_valid, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Picks at most one ready result per cycle from four functional units or the
// ROB load path, acknowledges it with a same-cycle yumi and broadcasts its
// packet on the registered common data bus one cycle later.
//
// Priority: a valid load wins unless some FU is waiting and the load has
// already won LOAD_STREAK_MAX times in a row while FUs were waiting; FUs are
// served round-robin starting at rr_ptr.
//
// Ports:
//   clk           single clock, rising edge
//   reset         synchronous, active-high
//   mispredicted  synchronous flush of the speculative backend
//   bus           cdb_arbiter_if.slave (result handshake + CDB broadcast)
//
// Yumi is combinational from the valids, mispredicted and reset; CDB,
// cdb_valid and cdb_src come straight from flops.
module cdb_arbiter #(
  parameter int LOAD_STREAK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mispredicted,
  cdb_arbiter_if.slave  bus
);

  localparam int STREAK_W = (LOAD_STREAK_MAX > 0) ? $clog2(LOAD_STREAK_MAX + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LOAD_STREAK_MAX);
  localparam logic [2:0] SRC_LOAD = 3'd4;

  logic [1:0]          rr_ptr;
  logic [STREAK_W-1:0] streak;

  logic       flush;
  logic       any_fu;
  logic       load_win;
  logic       fu_win;
  logic [1:0] fu_idx;
  logic [1:0] cand;
  logic       found;
  logic [3:0] yumi;

  assign flush  = reset | mispredicted;
  assign any_fu = |bus.valid_out_bus;

  // Round-robin search: first valid FU at rr_ptr, rr_ptr+1, ... (mod 4).
  // NOTE: every variable gets a default at the top of a combinational block
  // so that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    fu_idx = rr_ptr;
    found  = 1'b0;
    cand   = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!found && bus.valid_out_bus[cand]) begin
        fu_idx = cand;
        found  = 1'b1;
      end
    end
  end

  // The load is held back only when FUs are waiting and it has used up its
  // streak allowance; with no FU waiting it always wins.
  assign load_win = !flush && bus.load_valid && (!any_fu || (streak < STREAK_MAX));
  assign fu_win   = !flush && !load_win && found;

  always_comb begin
    yumi = '0;
    if (fu_win) begin
      yumi[fu_idx] = 1'b1;
    end
  end

  assign bus.yumi_bus  = yumi;
  assign bus.load_yumi = load_win;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (flush) begin
      // NOTE: the broadcast datapath is cleared as well as the control flops,
      // because consumers expect an all-zero CDB coming out of a flush.
      bus.CDB       <= '0;
      bus.cdb_valid <= 1'b0;
      bus.cdb_src   <= '0;
      rr_ptr        <= '0;
      streak        <= '0;
    end else if (load_win) begin
      bus.CDB       <= bus.out_load;
      bus.cdb_valid <= 1'b1;
      bus.cdb_src   <= SRC_LOAD;
      // The streak only counts loads that actually made an FU wait.
      if (any_fu) begin
        streak <= (streak == STREAK_MAX) ? streak : streak + STREAK_W'(1);
      end else begin
        streak <= '0;
      end
    end else if (fu_win) begin
      case (fu_idx)
        2'd0:    bus.CDB <= bus.out_0;
        2'd1:    bus.CDB <= bus.out_1;
        2'd2:    bus.CDB <= bus.out_2;
        default: bus.CDB <= bus.out_3;
      endcase
      bus.cdb_valid <= 1'b1;
      bus.cdb_src   <= {1'b0, fu_idx};
      rr_ptr        <= fu_idx + 2'd1;
      streak        <= '0;
    end else begin
      // Idle: packet and source hold so the last broadcast stays observable.
      bus.cdb_valid <= 1'b0;
    end
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Consumer end of the functional-unit result handshake and sole driver of the common data bus. Each cycle it selects at most one ready result from the four functional units (adder_fu_0, adder_fu_1, mult_fu, div_fu) or the ROB load path. It acknowledges the winner with a one-cycle yumi and broadcasts the winner's packet on a registered CDB to the reservation stations, regstat and ROB. It sits between the execute stage and the commit logic, and is flushed with the rest of the speculative backend on `mispredicted`.

## Interface
Parameters:
- `LOAD_STREAK_MAX`, default 4: consecutive load grants allowed while any FU is waiting, before one FU grant is forced.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `mispredicted`  in  1  synchronous flush (branch mispredict from new_pc)
- `valid_out_bus`  in  4  FU i holds a result on `out_i`
- `out_0`..`out_3`  in  CDB_packet_t  FU result packets, held stable until yumi
- `load_valid`  in  1  ROB has a completed load on `out_load`
- `out_load`  in  CDB_packet_t  load result packet
- `yumi_bus`  out  4  FU i result consumed this cycle
- `load_yumi`  out  1  load result consumed this cycle
- `CDB`  out  CDB_packet_t  registered broadcast packet
- `cdb_valid`  out  1  `CDB` carries a valid broadcast this cycle
- `cdb_src`  out  3  source of current broadcast: 0–3 = FU index, 4 = load

## Operation
- Packets pass through unmodified. The block never inspects fields other than the source valids.
- Internal state:
  - `rr_ptr[1:0]`: highest-priority FU.
  - `streak`: saturating count of consecutive load grants made while some FU was valid.
- Grant logic is combinational within a cycle, and is suppressed entirely when `mispredicted` or `reset` is high.
  - If `load_valid` is high and (no FU is valid, or `streak` < `LOAD_STREAK_MAX`), the load wins.
  - Otherwise, the first valid FU searching `rr_ptr`, `rr_ptr`+1, … mod 4 wins.
  - If nothing is valid, there is no grant.
- Yumi rules:
  - `yumi_bus`/`load_yumi` go high only for the winner, in the same cycle as the grant.
  - At most one of the five yumi bits is high in any cycle.
  - A yumi is never asserted to a source whose valid is low.
- On an FU grant to FU i: `rr_ptr` <= (i+1) mod 4 and `streak` <= 0.
- On a load grant:
  - If any FU is valid, `streak` <= min(`streak`+1, `LOAD_STREAK_MAX`).
  - Otherwise `streak` <= 0.
  - `rr_ptr` is unchanged.
- When nothing is granted, `rr_ptr` and `streak` are unchanged.
- Register update on every edge:
  - With a grant: `CDB` <= winner packet, `cdb_valid` <= 1, `cdb_src` <= winner.
  - Without a grant: `cdb_valid` <= 0, and `CDB`/`cdb_src` hold their previous values.
- Flush:
  - `reset` or `mispredicted` high at an edge sets `cdb_valid`, `CDB`, `cdb_src`, `rr_ptr` and `streak` to 0.
  - The yumi outputs are 0 during that cycle.

## Timing
- Reset values: `CDB` = all zero, `cdb_valid` = 0, `cdb_src` = 0, `yumi_bus` = 0, `load_yumi` = 0, `rr_ptr` = 0, `streak` = 0.
- Latency: a valid present in cycle N with a grant in N gives yumi in N and `cdb_valid`/`CDB` in N+1. This is one cycle from acceptance to broadcast.
- Throughput: one broadcast per cycle. Back-to-back grants produce back-to-back `cdb_valid`.
- Producer rule: a source keeps valid and its packet stable until it sees yumi. It may change the packet in the cycle after yumi. The arbiter makes no assumption about a valid deasserting without yumi, and treats such a source as no longer requesting.
- A source that re-presents a new result the cycle after its yumi may be granted again, subject to priority.
- `mispredicted` in cycle N:
  - No yumi is issued in N.
  - `cdb_valid` is 0 in N+1.
  - A broadcast already registered and visible in N remains visible in N. Consumers qualify it with `mispredicted`.
- Reset mid-operation behaves identically to `mispredicted`. Pending producer results are not acknowledged; producers are reset by the same signal.
- No combinational path exists from any input to `CDB`, `cdb_valid` or `cdb_src`. Yumi depends combinationally on the valids, `mispredicted` and `reset`.

## Test plan
- Reset, then single source: FU2 valid with `rob_entry` = 5 and value = 0x0000_00AA → `yumi_bus` = 0100 same cycle; next cycle `cdb_valid` = 1, `cdb_src` = 2, `CDB` = FU2 packet; following cycle `cdb_valid` = 0.
- Round-robin: all four FUs held valid for 8 cycles, no load → grant order 0,1,2,3,0,1,2,3, with one yumi per cycle and `cdb_valid` high for cycles 2–9.
- Load starvation guard: `load_valid` and FU1 held valid continuously, `LOAD_STREAK_MAX` = 4 → grants L,L,L,L,FU1,L,L,L,L,FU1, and FU1 yumi in cycles 5 and 10.
- Load alone: `load_valid` for 6 cycles, FUs idle → load granted every cycle, `streak` stays 0; then a valid FU0 arriving wins immediately once the load drops, and wins only after 4 load grants if the load stays valid.
- Mispredict flush: FU0 and FU3 valid, assert `mispredicted` for 1 cycle → `yumi_bus` = 0000 that cycle, `cdb_valid` = 0 next cycle, `rr_ptr` reset so FU0 wins the first post-flush grant.
- Hold behaviour: FU3 valid and granted, then idle for 3 cycles → `CDB` and `cdb_src` = 3 held, `cdb_valid` = 0 for all 3 idle cycles; assertion checks throughout that at most one yumi is high and no yumi goes to an invalid source.
